banco_registro_sb: RTL and testbench
====================================

Name: banco_registro_sb

Overview:
- Parametrised register file: one write port, two combinational read ports.
- Adds optional hardwired-zero register 0 and optional write-to-read bypass.
- Adds a per-register pending (busy) scoreboard and a sequential clear-sweep engine.
- Sits between a decode/issue stage, which marks destinations pending, and a writeback stage, which writes data and releases them.

Parameters:
- W, 8, data width in bits.
- N, 3, address width; depth = 2**N registers.
- ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes, never goes busy.
- BYPASS, 1, 1 = same-cycle write data and busy release are forwarded to the read ports.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- we  in  1  write enable.
- addr_rd  in  N  write address.
- data_in  in  W  write data.
- mark_we  in  1  set busy bit of mark_addr.
- mark_addr  in  N  register being marked pending.
- clr  in  1  start clear sweep (one-cycle pulse, sampled only when ready=1).
- addr_rs1  in  N  read address, port 1.
- addr_rs2  in  N  read address, port 2.
- rs1  out  W  read data, port 1.
- rs2  out  W  read data, port 2.
- rs1_busy  out  1  pending flag for addr_rs1.
- rs2_busy  out  1  pending flag for addr_rs2.
- ready  out  1  high when the FSM is in IDLE.

Behaviour:
- Reset (rst high at an edge): all 2**N registers = 0, all busy bits = 0, FSM = IDLE, sweep pointer = 0.
  - Outputs after reset: rs1 = rs2 = 0, rs1_busy = rs2_busy = 0, ready = 1.
  - rst overrides everything, including a sweep in progress; the sweep is aborted.
- FSM states: IDLE and CLEAR.
  - IDLE -> CLEAR when clr=1 at an edge.
  - CLEAR: each cycle zeroes reg[ptr] and busy[ptr], then ptr+1.
  - CLEAR -> IDLE at the edge that clears ptr = 2**N-1; ptr returns to 0.
  - Timing: clr sampled at edge t gives ready=0 for exactly 2**N cycles, ready=1 again after edge t+2**N.
- ready = (state == IDLE), combinational from state.
- In CLEAR:
  - we, mark_we and clr are ignored.
  - Reads return current array contents (partially cleared).
  - Bypass is disabled.
- Write (IDLE, we=1): reg[addr_rd] <= data_in and busy[addr_rd] <= 0 at the edge. If ZERO_REG=1 and addr_rd=0, the write is discarded.
- Mark (IDLE, mark_we=1): busy[mark_addr] <= 1. If ZERO_REG=1 and mark_addr=0, the mark is ignored.
- Write and mark to the same address in the same cycle: data is written and busy ends at 1 (the new producer wins).
- Write and mark to different addresses: both take effect.
- Read, combinational, rsX = reg[addr_rsX], with these overrides:
  - ZERO_REG=1 and addr_rsX=0: rsX = 0 and rsX_busy = 0.
  - BYPASS=1, IDLE, we=1, addr_rd = addr_rsX, and the address is not the hardwired zero: rsX = data_in.
  - Under the same bypass condition, rsX_busy = 0 unless mark_we=1 with mark_addr = addr_rsX, in which case rsX_busy = the registered busy bit.
  - BYPASS=0: reads show pre-edge contents; a write becomes visible the cycle after the edge.
  - Marks never forward; a mark becomes visible the cycle after the edge.
- Both read ports are independent and may address the same register.
- clr held high: it is resampled when back in IDLE, so a new sweep starts immediately.

Test Plan (W=8, N=3, ZERO_REG=1, BYPASS=1 unless stated):
- Reset then read: assert rst 1 cycle -> for every addr, rs1 = rs2 = 0x00, busy = 0, ready = 1. Write 0x5A to addr 0 -> rs1(addr 0) = 0x00.
- Write/read with bypass: we=1, addr_rd=3, data_in=0xA7, addr_rs1=3 in the same cycle -> rs1 = 0xA7 combinationally. Next cycle with we=0 -> rs1 = 0xA7. Repeat with BYPASS=0 -> rs1 shows old value 0x00 in the write cycle, 0xA7 after.
- Scoreboard: mark_addr=5 -> rs2_busy(5) = 1 the next cycle. Write 0x11 to addr 5 -> rs2_busy = 0 in the write cycle (bypass) and after. Write and mark addr 5 in the same cycle -> reg = 0x11, busy stays 1.
- Clear sweep: fill regs 1..7 with 0x10..0x70, mark all busy, pulse clr -> ready = 0 for exactly 8 cycles. A we to addr 2 during the sweep is ignored. Afterwards all regs read 0x00, all busy = 0, ready = 1.
- Reset mid-sweep: pulse clr, assert rst on the 3rd CLEAR cycle -> next cycle ready = 1, all regs 0, ptr restarts at 0 on the next clr.
- Dual-port collision: addr_rs1 = addr_rs2 = 6 holding 0xC3 -> both read 0xC3. A simultaneous write of 0x3C to addr 6 -> both read 0x3C via bypass.

Source files
------------

// File: rtl/banco_registro_sb_if.sv
// Register file bus: write/mark/clear requests in, read data and flags out.
// Master is the issue/writeback side, slave is the register file.
interface banco_registro_sb_if #(
  parameter int W = 8,
  parameter int N = 3
);
  logic         we;
  logic [N-1:0] addr_rd;
  logic [W-1:0] data_in;
  logic         mark_we;
  logic [N-1:0] mark_addr;
  logic         clr;
  logic [N-1:0] addr_rs1;
  logic [N-1:0] addr_rs2;
  logic [W-1:0] rs1;
  logic [W-1:0] rs2;
  logic         rs1_busy;
  logic         rs2_busy;
  logic         ready;

  modport master (
    output we, addr_rd, data_in,
    output mark_we, mark_addr, clr,
    output addr_rs1, addr_rs2,
    input  rs1, rs2, rs1_busy, rs2_busy,
    input  ready
  );

  modport slave (
    input  we, addr_rd, data_in,
    input  mark_we, mark_addr, clr,
    input  addr_rs1, addr_rs2,
    output rs1, rs2, rs1_busy, rs2_busy,
    output ready
  );
endinterface

// File: rtl/banco_registro_sb.sv
// Register file with pending scoreboard, optional zero register,
// write bypass and a one-register-per-cycle clear sweep.
module banco_registro_sb #(
  parameter int W        = 8,
  parameter int N        = 3,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic clk,
  input logic rst,
  banco_registro_sb_if.slave bus
);

  localparam int D = 2 ** N;
  localparam logic [N-1:0] LAST = '1;

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   ptr_q, ptr_d;
  logic [W-1:0]   regs_q [D];
  logic [W-1:0]   regs_d [D];
  logic [D-1:0]   busy_q, busy_d;

  logic           wr_ok;
  logic           mk_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      busy_q  <= '0;
      for (int i = 0; i < D; i++)
        regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      regs_q  <= regs_d;
    end
  end

  assign wr_ok = bus.we &&
    !(ZERO_REG != 0 && bus.addr_rd == '0);
  assign mk_ok = bus.mark_we &&
    !(ZERO_REG != 0 && bus.mark_addr == '0);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    regs_d  = regs_q;
    unique case (state_q)
      S_IDLE: begin
        if (wr_ok) begin
          regs_d[bus.addr_rd] = bus.data_in;
          busy_d[bus.addr_rd] = 1'b0;
        end
        // mark after write: a new producer wins
        if (mk_ok)
          busy_d[bus.mark_addr] = 1'b1;
        if (bus.clr)
          state_d = S_CLEAR;
      end
      S_CLEAR: begin
        regs_d[ptr_q] = '0;
        busy_d[ptr_q] = 1'b0;
        ptr_d         = ptr_q + 1'b1;
        if (ptr_q == LAST)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.ready = (state_q == S_IDLE);

  logic [N-1:0] ra [2];
  logic [W-1:0] rd [2];
  logic         bz [2];
  logic         zh [2];
  logic         bh [2];

  assign ra[0] = bus.addr_rs1;
  assign ra[1] = bus.addr_rs2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      zh[p] = (ZERO_REG != 0) && (ra[p] == '0);
      bh[p] = (BYPASS != 0) && !zh[p] &&
              (state_q == S_IDLE) && bus.we &&
              (bus.addr_rd == ra[p]);
      rd[p] = regs_q[ra[p]];
      bz[p] = busy_q[ra[p]];
      unique case (1'b1)
        zh[p]: begin
          rd[p] = '0;
          bz[p] = 1'b0;
        end
        bh[p]: begin
          rd[p] = bus.data_in;
          bz[p] = (bus.mark_we &&
                   bus.mark_addr == ra[p]) ?
                  busy_q[ra[p]] : 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.rs1      = rd[0];
  assign bus.rs2      = rd[1];
  assign bus.rs1_busy = bz[0];
  assign bus.rs2_busy = bz[1];

endmodule

// File: tb/tb_banco_registro_sb.sv
// Bench: bypass and non-bypass register files driven in lockstep,
// checked every cycle against a behavioural model.
module tb_banco_registro_sb;

  logic       clk = 1'b0;
  logic       rst;
  logic       we, mark_we, clr;
  logic [2:0] addr_rd, mark_addr, addr_rs1, addr_rs2;
  logic [7:0] data_in;

  always #5 clk = ~clk;

  banco_registro_sb_if #(.W(8), .N(3)) ba ();
  banco_registro_sb_if #(.W(8), .N(3)) bb ();

  assign ba.we = we;           assign bb.we = we;
  assign ba.addr_rd = addr_rd; assign bb.addr_rd = addr_rd;
  assign ba.data_in = data_in; assign bb.data_in = data_in;
  assign ba.mark_we = mark_we; assign bb.mark_we = mark_we;
  assign ba.mark_addr = mark_addr;
  assign bb.mark_addr = mark_addr;
  assign ba.clr = clr;         assign bb.clr = clr;
  assign ba.addr_rs1 = addr_rs1;
  assign bb.addr_rs1 = addr_rs1;
  assign ba.addr_rs2 = addr_rs2;
  assign bb.addr_rs2 = addr_rs2;

  banco_registro_sb #(.W(8), .N(3), .ZERO_REG(1), .BYPASS(1))
    u_byp (.clk(clk), .rst(rst), .bus(ba.slave));
  banco_registro_sb #(.W(8), .N(3), .ZERO_REG(1), .BYPASS(0))
    u_nob (.clk(clk), .rst(rst), .bus(bb.slave));

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  // model: register contents, pending bits, sweep cycles remaining
  logic [7:0] m_reg [8];
  bit         m_busy [8];
  int         m_left = 0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        m_reg[i] = 8'h00;
        m_busy[i] = 0;
      end
      m_left = 0;
    end else if (m_left > 0) begin
      m_reg[8 - m_left] = 8'h00;
      m_busy[8 - m_left] = 0;
      m_left--;
    end else begin
      if (we && addr_rd != 0) begin
        m_reg[addr_rd] = data_in;
        m_busy[addr_rd] = 0;
      end
      if (mark_we && mark_addr != 0)
        m_busy[mark_addr] = 1;
      if (clr) m_left = 8;
    end
  end

  function automatic bit fwd(logic [2:0] a, bit byp);
    return byp && a != 0 && m_left == 0 && we && addr_rd == a;
  endfunction

  function automatic logic [7:0] exp_rd(logic [2:0] a, bit byp);
    if (a == 0) return 8'h00;
    if (fwd(a, byp)) return data_in;
    return m_reg[a];
  endfunction

  function automatic logic exp_bz(logic [2:0] a, bit byp);
    if (a == 0) return 1'b0;
    if (fwd(a, byp))
      return (mark_we && mark_addr == a) ? m_busy[a] : 1'b0;
    return m_busy[a];
  endfunction

  task automatic cmp(string nm, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("byp.rs1", ba.rs1, exp_rd(addr_rs1, 1));
      cmp("byp.rs2", ba.rs2, exp_rd(addr_rs2, 1));
      cmp("byp.b1", ba.rs1_busy, exp_bz(addr_rs1, 1));
      cmp("byp.b2", ba.rs2_busy, exp_bz(addr_rs2, 1));
      cmp("byp.rdy", ba.ready, m_left == 0);
      cmp("nob.rs1", bb.rs1, exp_rd(addr_rs1, 0));
      cmp("nob.rs2", bb.rs2, exp_rd(addr_rs2, 0));
      cmp("nob.b1", bb.rs1_busy, exp_bz(addr_rs1, 0));
      cmp("nob.b2", bb.rs2_busy, exp_bz(addr_rs2, 0));
      cmp("nob.rdy", bb.ready, m_left == 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    we = 0; mark_we = 0; clr = 0;
  endtask

  task automatic wr(logic [2:0] a, logic [7:0] d);
    we = 1; addr_rd = a; data_in = d;
    tick();
    we = 0;
  endtask

  int cnt;

  initial begin
    rst = 1; idle_in();
    addr_rd = 0; data_in = 0; mark_addr = 0;
    addr_rs1 = 0; addr_rs2 = 0;
    tick();
    rst = 0;
    chk_en = 1;

    // reset state on every address
    for (int a = 0; a < 8; a++) begin
      addr_rs1 = 3'(a); addr_rs2 = 3'(7 - a);
      #1;
      cmp("rst.rs1", ba.rs1, 8'h00);
      cmp("rst.rs2", ba.rs2, 8'h00);
      cmp("rst.bsy", ba.rs1_busy | ba.rs2_busy, 0);
      cmp("rst.rdy", ba.ready, 1);
      tick();
    end

    // hardwired zero
    addr_rs1 = 0;
    wr(3'd0, 8'h5A);
    #1 cmp("zero.rs1", ba.rs1, 8'h00);

    // bypass vs non-bypass write visibility
    addr_rs1 = 3; we = 1; addr_rd = 3; data_in = 8'hA7;
    #1;
    cmp("byp.wcyc", ba.rs1, 8'hA7);
    cmp("nob.wcyc", bb.rs1, 8'h00);
    tick(); we = 0; #1;
    cmp("byp.after", ba.rs1, 8'hA7);
    cmp("nob.after", bb.rs1, 8'hA7);

    // scoreboard
    addr_rs2 = 5; mark_we = 1; mark_addr = 5;
    #1 cmp("mark.nofwd", ba.rs2_busy, 0);
    tick(); mark_we = 0; #1;
    cmp("mark.vis", ba.rs2_busy, 1);
    we = 1; addr_rd = 5; data_in = 8'h11; #1;
    cmp("rel.byp", ba.rs2_busy, 0);
    cmp("rel.nob", bb.rs2_busy, 1);
    cmp("rel.data", ba.rs2, 8'h11);
    tick(); we = 0; #1;
    cmp("rel.after", bb.rs2_busy, 0);
    we = 1; mark_we = 1; #1;
    cmp("wm.fwdbusy", ba.rs2_busy, 0);
    tick(); idle_in(); #1;
    cmp("wm.data", ba.rs2, 8'h11);
    cmp("wm.busy", ba.rs2_busy, 1);

    // fill, mark all, sweep
    for (int i = 1; i < 8; i++) begin
      mark_we = 1; mark_addr = 3'(i);
      wr(3'(i), 8'(i * 16));
    end
    idle_in();
    clr = 1; tick(); clr = 0;
    we = 1; addr_rd = 2; data_in = 8'hFF;
    cnt = 0;
    while (!ba.ready && cnt < 20) begin
      if (cnt == 1) we = 0;
      tick();
      cnt++;
    end
    we = 0;
    cmp("sweep.len", cnt, 8);
    for (int a = 0; a < 8; a++) begin
      addr_rs1 = 3'(a); #1;
      cmp("sweep.rd", ba.rs1, 8'h00);
      cmp("sweep.bz", ba.rs1_busy, 0);
    end

    // reset in the third sweep cycle
    wr(3'd1, 8'h11);
    wr(3'd7, 8'h77);
    clr = 1; tick(); clr = 0;
    tick(); tick();
    rst = 1; tick(); rst = 0; #1;
    cmp("mid.rdy", ba.ready, 1);
    addr_rs1 = 7; #1 cmp("mid.r7", ba.rs1, 8'h00);
    wr(3'd1, 8'h22);
    wr(3'd7, 8'h77);
    clr = 1; tick(); clr = 0;
    tick(); tick();
    addr_rs1 = 1; addr_rs2 = 7; #1;
    cmp("ptr.r1", ba.rs1, 8'h00);
    cmp("ptr.r7", ba.rs2, 8'h77);
    cnt = 0;
    while (!ba.ready && cnt < 20) begin
      tick(); cnt++;
    end
    cmp("ptr.done", ba.ready, 1);

    // dual-port collision
    wr(3'd6, 8'hC3);
    addr_rs1 = 6; addr_rs2 = 6; #1;
    cmp("dual.r1", ba.rs1, 8'hC3);
    cmp("dual.r2", ba.rs2, 8'hC3);
    we = 1; addr_rd = 6; data_in = 8'h3C; #1;
    cmp("dual.b1", ba.rs1, 8'h3C);
    cmp("dual.b2", ba.rs2, 8'h3C);
    cmp("dual.n1", bb.rs1, 8'hC3);
    tick(); we = 0;

    // clr held high restarts sweeps back to back
    clr = 1;
    for (int i = 0; i < 12; i++) tick();
    clr = 0;
    cnt = 0;
    while (!ba.ready && cnt < 20) begin
      tick(); cnt++;
    end
    cmp("hold.done", ba.ready, 1);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
